// File: rtl/cook_time_entry.sv
// Egg-timer programming controller: button pulses edit four BCD digits, then drive load/run/alarm.
// Optional build macro ALARM_TIMEOUT_EN: alarm self-clears after ALARM_CYCLES cycles in DONE.
module cook_time_entry #(
  parameter int SEC_MAX      = 9,
  parameter int TENS_SEC_MAX = 5,
  parameter int MIN_MAX      = 9,
  parameter int TENS_MIN_MAX = 9,
  parameter int ALARM_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       timer_done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load,
  output logic       run,
  output logic       alarm,
  output logic [1:0] edit_digit,
  output logic       editing
);

  typedef enum logic [2:0] {
    ST_EDIT,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  // Parameter sanity: digits must be BCD and the alarm hold at least one cycle.
  if (SEC_MAX > 9 || TENS_SEC_MAX > 9 || MIN_MAX > 9 || TENS_MIN_MAX > 9 ||
      SEC_MAX < 1 || TENS_SEC_MAX < 1 || MIN_MAX < 1 || TENS_MIN_MAX < 1 ||
      ALARM_CYCLES < 1) begin : g_param_check
    $error("cook_time_entry: illegal parameter value");
  end

  state_t      state_reg, state_next;
  logic [1:0]  cursor_reg, cursor_next;
  logic        load_reg, run_reg, alarm_reg, editing_reg;
  logic [15:0] digits_flat;
  logic        digits_nonzero;
  logic        any_btn;
  logic        do_up, do_down;

  assign digits_nonzero = |digits_flat;
  assign any_btn        = btn_next | btn_up | btn_down | btn_start;

`ifdef ALARM_TIMEOUT_EN
  localparam int CNT_W = $clog2(ALARM_CYCLES) + 1;
  logic [CNT_W-1:0] alarm_cnt_reg, alarm_cnt_next;
  logic             alarm_expired;

  // Counter runs only while in DONE, so it restarts from zero on every entry.
  assign alarm_cnt_next = (state_reg == ST_DONE) ? alarm_cnt_reg + 1'b1 : '0;
  assign alarm_expired  = (alarm_cnt_reg == CNT_W'(ALARM_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_cnt_reg <= '0;
    end else begin
      alarm_cnt_reg <= alarm_cnt_next;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    cursor_next = cursor_reg;
    do_up       = 1'b0;
    do_down     = 1'b0;
    case (state_reg)
      ST_EDIT: begin
        // start outranks every other button even when it is refused for an all-zero time
        if (btn_start) begin
          if (digits_nonzero) begin
            state_next = ST_LOAD;
          end
        end else if (btn_next) begin
          cursor_next = cursor_reg + 2'd1;
        end else if (btn_up) begin
          do_up = 1'b1;
        end else if (btn_down) begin
          do_down = 1'b1;
        end
      end
      ST_LOAD: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (timer_done) begin
          state_next = ST_DONE;
        end else if (btn_start) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_start) begin
          state_next = ST_RUN;
        end else if (btn_next) begin
          state_next  = ST_EDIT;
          cursor_next = 2'd0;
        end
      end
      ST_DONE: begin
        if (any_btn) begin
          state_next = ST_EDIT;
        end
`ifdef ALARM_TIMEOUT_EN
        else if (alarm_expired) begin
          state_next = ST_EDIT;
        end
`endif
      end
      default: begin
        state_next = ST_EDIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_EDIT;
      cursor_reg  <= 2'd0;
      load_reg    <= 1'b0;
      run_reg     <= 1'b0;
      alarm_reg   <= 1'b0;
      editing_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cursor_reg  <= cursor_next;
      load_reg    <= (state_next == ST_LOAD);
      run_reg     <= (state_next == ST_RUN);
      alarm_reg   <= (state_next == ST_DONE);
      editing_reg <= (state_next == ST_EDIT);
    end
  end

  // One register per digit; each wraps within its own maximum.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    localparam logic [3:0] DMAX = (gi == 0) ? 4'(SEC_MAX) :
                                  (gi == 1) ? 4'(TENS_SEC_MAX) :
                                  (gi == 2) ? 4'(MIN_MAX) : 4'(TENS_MIN_MAX);
    logic [3:0] digit_reg, digit_next;

    always_comb begin
      digit_next = digit_reg;
      if (cursor_reg == 2'(gi)) begin
        if (do_up) begin
          digit_next = (digit_reg >= DMAX) ? 4'd0 : digit_reg + 4'd1;
        end else if (do_down) begin
          digit_next = (digit_reg == 4'd0) ? DMAX : digit_reg - 4'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        digit_reg <= 4'd0;
      end else begin
        digit_reg <= digit_next;
      end
    end

    assign digits_flat[gi*4 +: 4] = digit_reg;
  end

  assign seconds_prog      = digits_flat[3:0];
  assign tens_seconds_prog = digits_flat[7:4];
  assign minutes_prog      = digits_flat[11:8];
  assign tens_minutes_prog = digits_flat[15:12];
  assign load              = load_reg;
  assign run               = run_reg;
  assign alarm             = alarm_reg;
  assign edit_digit        = cursor_reg;
  assign editing           = editing_reg;

endmodule

// File: tb/tb_cook_time_entry.sv
// Randomized plus directed bench for cook_time_entry against a behavioural model of the timer controller.
module tb_cook_time_entry;

  localparam int ALARM_CYCLES = 16;
  localparam int M_EDIT = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic       timer_done = 1'b0;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       load, run, alarm, editing;
  logic [1:0] edit_digit;

  cook_time_entry dut (
    .clk               (clk),
    .reset             (reset),
    .btn_next          (btn_next),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_start         (btn_start),
    .timer_done        (timer_done),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .load              (load),
    .run               (run),
    .alarm             (alarm),
    .edit_digit        (edit_digit),
    .editing           (editing)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Reference model state
  int m_digit [4];
  int m_max   [4] = '{9, 5, 9, 9};
  int m_cursor;
  int m_mode;
  int m_done_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // b = {start, next, up, down}
  task automatic model_step(input logic [3:0] b, input logic td, input logic rs);
    int c;
    if (rs) begin
      for (int i = 0; i < 4; i++) m_digit[i] = 0;
      m_cursor = 0;
      m_mode   = M_EDIT;
      m_done_cycles = 0;
      return;
    end
    c = m_cursor;
    case (m_mode)
      M_EDIT: begin
        if (b[3]) begin
          if (m_digit[0] + m_digit[1] + m_digit[2] + m_digit[3] > 0) m_mode = M_LOAD;
        end else if (b[2]) m_cursor = (m_cursor + 1) % 4;
        else if (b[1]) m_digit[c] = (m_digit[c] + 1) % (m_max[c] + 1);
        else if (b[0]) m_digit[c] = (m_digit[c] + m_max[c]) % (m_max[c] + 1);
      end
      M_LOAD: m_mode = M_RUN;
      M_RUN: begin
        if (td) begin
          m_mode = M_DONE;
          m_done_cycles = 0;
        end else if (b[3]) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (b[3]) m_mode = M_RUN;
        else if (b[2]) begin
          m_mode = M_EDIT;
          m_cursor = 0;
        end
      end
      default: begin
        if (b != 4'b0) m_mode = M_EDIT;
`ifdef ALARM_TIMEOUT_EN
        else begin
          m_done_cycles++;
          if (m_done_cycles == ALARM_CYCLES) m_mode = M_EDIT;
        end
`endif
      end
    endcase
  endtask

  task automatic step(input logic [3:0] b, input logic td, input logic rs);
    {btn_start, btn_next, btn_up, btn_down} = b;
    timer_done = td;
    reset      = rs;
    @(posedge clk);
    model_step(b, td, rs);
    #1;
    {btn_start, btn_next, btn_up, btn_down} = 4'b0;
    timer_done = 1'b0;
    reset      = 1'b0;
    check("digits", {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog},
          {4'(m_digit[3]), 4'(m_digit[2]), 4'(m_digit[1]), 4'(m_digit[0])});
    check("cursor", 32'(edit_digit), 32'(m_cursor));
    check("flags", {load, run, alarm, editing},
          {m_mode == M_LOAD, m_mode == M_RUN, m_mode == M_DONE, m_mode == M_EDIT});
  endtask

  localparam logic [3:0] B_NONE = 4'b0000, B_START = 4'b1000, B_NEXT = 4'b0100,
                         B_UP = 4'b0010, B_DOWN = 4'b0001;

  initial begin
    logic [3:0] b;
    logic       td, rs;
    int         r;

    // Reset state and 1:30 entry
    step(B_NONE, 1'b0, 1'b1);
    check("reset_editing", 32'(editing), 32'd1);
    step(B_NEXT, 1'b0, 1'b0);
    repeat (3) step(B_UP, 1'b0, 1'b0);
    step(B_NEXT, 1'b0, 1'b0);
    step(B_UP, 1'b0, 1'b0);
    check("tens_sec_130", 32'(tens_seconds_prog), 32'd3);
    check("min_130", 32'(minutes_prog), 32'd1);
    step(B_START, 1'b0, 1'b0);
    check("load_pulse", {load, run}, 2'b10);
    step(B_NONE, 1'b0, 1'b0);
    check("run_after_load", {load, run}, 2'b01);

    // Pause / resume without reload
    step(B_START, 1'b0, 1'b0);
    check("paused", 32'(run), 32'd0);
    step(B_NONE, 1'b0, 1'b0);
    step(B_START, 1'b0, 1'b0);
    check("resumed", {load, run}, 2'b01);

    // timer_done beats start
    step(B_START, 1'b1, 1'b0);
    check("done_alarm", {alarm, run}, 2'b10);
    step(B_UP, 1'b0, 1'b0);
    check("done_exit", {editing, tens_seconds_prog, minutes_prog}, {1'b1, 4'd3, 4'd1});

    // Down/up wrap on tens_seconds
    step(B_NONE, 1'b0, 1'b1);
    step(B_NEXT, 1'b0, 1'b0);
    step(B_DOWN, 1'b0, 1'b0);
    check("down_wrap", 32'(tens_seconds_prog), 32'd5);
    step(B_UP, 1'b0, 1'b0);
    check("up_wrap", 32'(tens_seconds_prog), 32'd0);

    // Priority: up beats down, next beats up
    step(B_UP | B_DOWN, 1'b0, 1'b0);
    check("prio_up", 32'(tens_seconds_prog), 32'd1);
    step(B_NEXT | B_UP, 1'b0, 1'b0);
    check("prio_next", {edit_digit, minutes_prog}, {2'd2, 4'd0});

    // Zero start ignored
    step(B_NONE, 1'b0, 1'b1);
    step(B_START, 1'b0, 1'b0);
    check("zero_start", {load, run, editing}, 3'b001);
    step(B_NONE, 1'b0, 1'b0);
    check("zero_start_idle", {load, run, editing}, 3'b001);

    // Reset during RUN
    step(B_UP, 1'b0, 1'b0);
    step(B_START, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b1);
    check("reset_in_run", {load, run, alarm, seconds_prog}, {3'b000, 4'd0});

`ifdef ALARM_TIMEOUT_EN
    step(B_UP, 1'b0, 1'b0);
    step(B_START, 1'b0, 1'b0);
    step(B_NONE, 1'b0, 1'b0);
    step(B_NONE, 1'b1, 1'b0);
    for (int i = 0; i < ALARM_CYCLES - 1; i++) begin
      step(B_NONE, 1'b0, 1'b0);
      check("alarm_hold", 32'(alarm), 32'd1);
    end
    step(B_NONE, 1'b0, 1'b0);
    check("alarm_timeout", {alarm, editing}, 2'b01);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 15);
      b  = B_NONE;
      if (r < 4) b = 4'(1 << r);
      else if (r == 4) b = 4'($urandom_range(0, 15));
      td = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(b, td, rs);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
